svi_field_wr_arbiter: RTL and testbench
=======================================

// Module: svi_field_wr_arbiter
// PURPOSE
//  Shares one W-bit register set (fields z,y,x of the shared SVI) between N_REQ requesters.
//  Each requester offers masked writes over a valid/ready handshake. The block grants
//  round-robin, with an optional lock for atomic multi-beat sequences. It is the single
//  always_ff driver of the fields, so no field has multiple procedural drivers.
// PARAMETERS
//  N_REQ     4      number of requesters, >=2
//  W         3      field width; bit2=z, bit1=y, bit0=x
//  RST_VAL   3'b000 field value after i_arst or i_srst
//  LOCK_MAX  8      max cycles a lock may be held before forced release, >=1
// PORTS
//  i_clk      in   1             single clock, rising edge
//  i_arst     in   1             asynchronous reset, active-high
//  i_srst     in   1             synchronous clear, active-high
//  i_valid    in   N_REQ         per-requester write request
//  i_lock     in   N_REQ         beat requests/keeps ownership after acceptance
//  i_data     in   N_REQ*W       write data, requester r at [r*W +: W]
//  i_mask     in   N_REQ*W       per-bit write enable, same packing
//  o_ready    out  N_REQ         one-hot or zero; accept = i_valid[r] & o_ready[r]
//  o_fields   out  W             registered shared fields (drive z,y,x)
//  o_owner    out  clog2(N_REQ)  current lock owner; 0 when unlocked
//  o_locked   out  1             FSM is in LOCKED
//  o_timeout  out  1             1-cycle pulse on forced lock release
// BEHAVIOUR
//  Reset (i_arst async, or i_srst at an edge):
//   - o_fields=RST_VAL; FSM=ARB; ptr=0; o_owner=0; o_locked=0; o_timeout=0; lock counter=0.
//   - o_ready=0 while i_srst=1; i_srst overrides any accept in the same cycle.
//  Acceptance and write:
//   - At most one acceptance per cycle.
//   - o_ready is combinational from FSM state, ptr and i_valid. i_valid must not depend on o_ready.
//   - Accepted beat updates next edge: o_fields <= (o_fields & ~mask) | (data & mask).
//   - Latency is 1 cycle. A mask of all zeros is accepted and leaves the fields unchanged.
//   - Requester holds valid/data/mask/lock stable until accepted.
//  FSM ARB:
//   - Grant the first valid requester scanning ptr, ptr+1, ... mod N_REQ.
//   - On accept of requester g: ptr <= (g+1) mod N_REQ.
//   - If i_lock[g]=1: -> LOCKED, owner=g, counter=0.
//   - No valid requester: o_ready=0, state and ptr unchanged.
//  FSM LOCKED:
//   - o_ready[owner]=i_valid[owner]; all other ready=0.
//   - counter increments every LOCKED cycle, including beat cycles and idle cycles.
//   - Owner accept with i_lock=0: write applied; -> ARB; o_owner=0.
//   - Owner accept with i_lock=1: write applied; stay LOCKED.
//   - counter reaches LOCK_MAX-1 with no release: -> ARB, o_timeout=1 for 1 cycle.
//     A beat accepted in that cycle is still written.
//   - ptr stays owner+1 during and after the lock, so the owner is lowest priority next.
//  Simultaneous events:
//   - i_srst beats accept and timeout.
//   - Release-by-beat and timeout in the same cycle: treated as a release, o_timeout=0.
//  i_arst mid-lock or mid-burst: immediate return to reset values; nothing is replayed.
//  Widths: ptr, owner and counter wrap modulo their range. All outputs are glitch-free
//   registers except o_ready.
// TESTING
//  1 Reset: pulse i_arst with clock stopped -> o_fields=000, o_ready=0, o_locked=0 at once.
//  2 Round-robin: all 4 valid, lock=0, data=r, mask=111 for 8 cycles
//    -> grants 0,1,2,3,0,1,2,3; o_fields trails the accepted data by 1 cycle.
//  3 Masked write: fields=101; r2 writes data=010, mask=010 -> fields=111 next cycle;
//    mask=000 -> fields unchanged, beat still accepted.
//  4 Lock: r1 sends 3 beats lock=1,1,0 while r0 and r3 are valid
//    -> only r1 is ready for those beats; next grant goes to r3 (ptr=2, r2 idle).
//  5 Timeout: LOCK_MAX=8, r2 locks then idles -> o_timeout pulses 8 cycles after entry,
//    then ARB grants r3 then r0.
//  6 i_srst while LOCKED with an owner beat valid -> beat not written, fields=RST_VAL,
//    FSM=ARB, ptr=0.

Source files
------------

// File: rtl/svi_field_wr_arbiter.sv
// Round-robin arbiter owning the shared z/y/x field register.
// Requesters issue masked writes; a lock gives one requester atomic multi-beat access.
module svi_field_wr_arbiter #(
   parameter int             N_REQ    = 4,
   parameter int             W        = 3,
   parameter logic [W-1:0]   RST_VAL  = '0,
   parameter int             LOCK_MAX = 8
) (
   input  logic                     i_clk,
   input  logic                     i_arst,
   input  logic                     i_srst,
   input  logic [N_REQ-1:0]         i_valid,
   input  logic [N_REQ-1:0]         i_lock,
   input  logic [N_REQ*W-1:0]       i_data,
   input  logic [N_REQ*W-1:0]       i_mask,
   output logic [N_REQ-1:0]         o_ready,
   output logic [W-1:0]             o_fields,
   output logic [$clog2(N_REQ)-1:0] o_owner,
   output logic                     o_locked,
   output logic                     o_timeout
);

   localparam int PW = $clog2(N_REQ);
   localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

   typedef enum logic {
      ST_ARB,
      ST_LOCKED
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    fields_q, fields_d;
   logic            timeout_q, timeout_d;

   logic            gnt_found;
   logic [PW-1:0]   gnt_idx;
   logic [N_REQ-1:0] ready;
   logic            acc;
   logic [PW-1:0]   acc_idx;
   logic [W-1:0]    acc_data;
   logic [W-1:0]    acc_mask;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
      if (int'(v) == N_REQ - 1) begin
         return '0;
      end
      return v + 1'b1;
   endfunction

   // Scan from ptr upward, wrapping at N_REQ; first valid requester wins.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         int            j;
         logic [PW-1:0] jj;
         j = int'(ptr_q) + k;
         if (j >= N_REQ) begin
            j = j - N_REQ;
         end
         jj = PW'(j);
         if (!gnt_found && i_valid[jj]) begin
            gnt_found = 1'b1;
            gnt_idx   = jj;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      ready     = '0;
      acc       = 1'b0;
      acc_idx   = '0;

      if (i_srst) begin
         state_d = ST_ARB;
         ptr_d   = '0;
         owner_d = '0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            ST_ARB: begin
               if (gnt_found) begin
                  ready[gnt_idx] = 1'b1;
                  acc            = 1'b1;
                  acc_idx        = gnt_idx;
                  ptr_d          = wrap_inc(gnt_idx);
                  if (i_lock[gnt_idx]) begin
                     state_d = ST_LOCKED;
                     owner_d = gnt_idx;
                     cnt_d   = '0;
                  end
               end
            end
            ST_LOCKED: begin
               cnt_d          = cnt_q + 1'b1;
               ready[owner_q] = i_valid[owner_q];
               acc            = i_valid[owner_q];
               acc_idx        = owner_q;
               // An explicit release wins over a timeout in the same cycle.
               if (acc && !i_lock[owner_q]) begin
                  state_d = ST_ARB;
                  owner_d = '0;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d   = ST_ARB;
                  owner_d   = '0;
                  cnt_d     = '0;
                  timeout_d = 1'b1;
               end
            end
            default: begin
               state_d = ST_ARB;
            end
         endcase
      end
   end

   assign acc_data = i_data[int'(acc_idx)*W +: W];
   assign acc_mask = i_mask[int'(acc_idx)*W +: W];

   always_comb begin
      fields_d = fields_q;
      if (i_srst) begin
         fields_d = RST_VAL;
      end else if (acc) begin
         fields_d = (fields_q & ~acc_mask) | (acc_data & acc_mask);
      end
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state_q   <= ST_ARB;
         ptr_q     <= '0;
         owner_q   <= '0;
         cnt_q     <= '0;
         fields_q  <= RST_VAL;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         owner_q   <= owner_d;
         cnt_q     <= cnt_d;
         fields_q  <= fields_d;
         timeout_q <= timeout_d;
      end
   end

   assign o_ready   = ready;
   assign o_fields  = fields_q;
   assign o_owner   = owner_q;
   assign o_locked  = (state_q == ST_LOCKED);
   assign o_timeout = timeout_q;

endmodule

// File: tb/tb_svi_field_wr_arbiter.sv
// Scoreboard bench: a cycle-level reference model predicts ready and register
// state per cycle; a separate monitor pops predictions and compares.
module tb_svi_field_wr_arbiter;

   localparam int N    = 4;
   localparam int W    = 3;
   localparam int LMAX = 8;

   logic             clk;
   logic             clk_en;
   logic             i_arst;
   logic             i_srst;
   logic [N-1:0]     i_valid;
   logic [N-1:0]     i_lock;
   logic [N*W-1:0]   i_data;
   logic [N*W-1:0]   i_mask;
   logic [N-1:0]     o_ready;
   logic [W-1:0]     o_fields;
   logic [1:0]       o_owner;
   logic             o_locked;
   logic             o_timeout;

   svi_field_wr_arbiter #(
      .N_REQ(N), .W(W), .RST_VAL(3'b000), .LOCK_MAX(LMAX)
   ) dut (
      .i_clk(clk), .i_arst(i_arst), .i_srst(i_srst),
      .i_valid(i_valid), .i_lock(i_lock),
      .i_data(i_data), .i_mask(i_mask),
      .o_ready(o_ready), .o_fields(o_fields),
      .o_owner(o_owner), .o_locked(o_locked),
      .o_timeout(o_timeout)
   );

   typedef struct {
      logic [N-1:0] ready;
      logic [W-1:0] fields;
      logic         locked;
      logic [1:0]   owner;
      logic         timeout;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state: owner = -1 means no lock held
   logic [W-1:0] m_fields;
   int           m_ptr;
   int           m_owner;
   int           m_held;
   int           last_acc;

   initial begin
      clk = 1'b0;
      wait (clk_en);
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic model_reset();
      m_fields = 3'b000;
      m_ptr    = 0;
      m_owner  = -1;
      m_held   = 0;
   endtask

   task automatic model_step(input logic [N-1:0] v, input logic [N-1:0] lk,
                             input logic [N*W-1:0] d,
                             input logic [N*W-1:0] m,
                             input logic s, output exp_t e);
      int g;
      logic [W-1:0] dd;
      logic [W-1:0] mm;
      e.ready   = '0;
      e.timeout = 1'b0;
      g         = -1;
      if (s) begin
         model_reset();
      end else if (m_owner < 0) begin
         for (int k = 0; k < N; k++) begin
            int r;
            r = (m_ptr + k) % N;
            if (g < 0 && v[r]) g = r;
         end
         if (g >= 0) begin
            m_ptr = (g + 1) % N;
            if (lk[g]) begin
               m_owner = g;
               m_held  = 0;
            end
         end
      end else begin
         m_held++;
         if (v[m_owner]) g = m_owner;
         if (g >= 0 && !lk[g]) begin
            m_owner = -1;
         end else if (m_held == LMAX) begin
            m_owner   = -1;
            e.timeout = 1'b1;
         end
      end
      if (g >= 0) begin
         dd         = d[g*W +: W];
         mm         = m[g*W +: W];
         e.ready[g] = 1'b1;
         m_fields   = (m_fields & ~mm) | (dd & mm);
      end
      last_acc = g;
      e.fields = m_fields;
      e.locked = (m_owner >= 0);
      e.owner  = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
   endtask

   task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] lk,
                        input logic [N*W-1:0] d,
                        input logic [N*W-1:0] m,
                        input logic s, input logic a);
      exp_t e;
      @(negedge clk);
      #1;
      if (a) begin
         i_arst = 1'b1;
         #1;
         model_reset();
         chk("arst_fields", 32'(o_fields), 32'(m_fields));
         chk("arst_locked", 32'(o_locked), 32'd0);
         i_arst = 1'b0;
      end
      i_valid = v;
      i_lock  = lk;
      i_data  = d;
      i_mask  = m;
      i_srst  = s;
      model_step(v, lk, d, m, s, e);
      exp_q.push_back(e);
   endtask

   // Monitor: ready before the edge, registered outputs after it
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #4;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("ready", 32'(o_ready), 32'(e.ready));
            @(posedge clk);
            #1;
            chk("fields", 32'(o_fields), 32'(e.fields));
            chk("locked", 32'(o_locked), 32'(e.locked));
            chk("owner", 32'(o_owner), 32'(e.owner));
            chk("timeout", 32'(o_timeout), 32'(e.timeout));
         end
      end
   end

   initial begin
      logic [N-1:0]   pv;
      logic [N-1:0]   plk;
      logic [N*W-1:0] pd;
      logic [N*W-1:0] pm;
      logic           s;
      clk_en  = 1'b0;
      i_arst  = 1'b0;
      i_srst  = 1'b0;
      i_valid = '0;
      i_lock  = '0;
      i_data  = '0;
      i_mask  = '0;
      model_reset();

      // Asynchronous reset with the clock stopped
      #2 i_arst = 1'b1;
      #1;
      chk("rst_fields", 32'(o_fields), 32'd0);
      chk("rst_ready", 32'(o_ready), 32'd0);
      chk("rst_locked", 32'(o_locked), 32'd0);
      chk("rst_timeout", 32'(o_timeout), 32'd0);
      #1 i_arst = 1'b0;
      clk_en = 1'b1;

      // Round robin, all requesters valid
      cycle(4'h0, 4'h0, '0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++)
         cycle(4'hF, 4'h0, {3'd3, 3'd2, 3'd1, 3'd0}, {4{3'b111}}, 1'b0, 1'b0);

      // Masked writes
      cycle(4'h0, 4'h0, '0, '0, 1'b1, 1'b0);
      cycle(4'h1, 4'h0, {9'd0, 3'b101}, {9'd0, 3'b111}, 1'b0, 1'b0);
      cycle(4'h4, 4'h0, {3'd0, 3'b010, 6'd0}, {3'd0, 3'b010, 6'd0}, 1'b0, 1'b0);
      cycle(4'h4, 4'h0, {3'd0, 3'b000, 6'd0}, '0, 1'b0, 1'b0);

      // r1 three-beat lock while r0 and r3 wait; r3 wins next
      cycle(4'h0, 4'h0, '0, '0, 1'b1, 1'b0);
      cycle(4'h2, 4'h2, {6'd0, 3'b001, 3'd0}, {4{3'b111}}, 1'b0, 1'b0);
      cycle(4'hB, 4'h2, {3'b100, 3'd0, 3'b011, 3'b110}, {4{3'b111}}, 1'b0, 1'b0);
      cycle(4'hB, 4'h0, {3'b100, 3'd0, 3'b010, 3'b110}, {4{3'b111}}, 1'b0, 1'b0);
      cycle(4'h9, 4'h0, {3'b100, 3'd0, 3'd0, 3'b110}, {4{3'b111}}, 1'b0, 1'b0);
      cycle(4'h1, 4'h0, {9'd0, 3'b110}, {4{3'b111}}, 1'b0, 1'b0);

      // r2 locks then idles until forced release
      cycle(4'h0, 4'h0, '0, '0, 1'b1, 1'b0);
      cycle(4'h4, 4'h4, {3'd0, 3'b111, 6'd0}, {4{3'b111}}, 1'b0, 1'b0);
      for (int i = 0; i < LMAX; i++)
         cycle(4'h0, 4'h0, '0, '0, 1'b0, 1'b0);
      cycle(4'h9, 4'h0, {3'b001, 6'd0, 3'b010}, {4{3'b111}}, 1'b0, 1'b0);
      cycle(4'h1, 4'h0, {9'd0, 3'b010}, {4{3'b111}}, 1'b0, 1'b0);

      // Sync clear beats an owner beat
      cycle(4'h2, 4'h2, {6'd0, 3'b101, 3'd0}, {4{3'b111}}, 1'b0, 1'b0);
      cycle(4'h2, 4'h2, {6'd0, 3'b111, 3'd0}, {4{3'b111}}, 1'b1, 1'b0);
      cycle(4'h2, 4'h0, {6'd0, 3'b011, 3'd0}, {4{3'b111}}, 1'b0, 1'b0);

      // Async reset in the middle of a lock
      cycle(4'h1, 4'h1, {9'd0, 3'b111}, {4{3'b111}}, 1'b0, 1'b0);
      cycle(4'h0, 4'h0, '0, '0, 1'b0, 1'b1);
      cycle(4'h8, 4'h0, {3'b100, 9'd0}, {4{3'b111}}, 1'b0, 1'b0);

      // Randomized traffic; requesters hold a beat until it is accepted
      pv  = '0;
      plk = '0;
      pd  = '0;
      pm  = '0;
      for (int i = 0; i < 3000; i++) begin
         for (int r = 0; r < N; r++) begin
            int p;
            p = (r == m_owner) ? 6 : 2;
            if (!pv[r] && $urandom_range(p - 1) == 0) begin
               pv[r]         = 1'b1;
               plk[r]        = ($urandom_range(2) == 0);
               pd[r*W +: W]  = 3'($urandom);
               pm[r*W +: W]  = 3'($urandom);
            end
         end
         s = ($urandom_range(59) == 0);
         cycle(pv, plk, pd, pm, s, 1'b0);
         if (last_acc >= 0) pv[last_acc] = 1'b0;
      end

      cycle('0, '0, '0, '0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
